aes_frame_packer: RTL and testbench
===================================

# aes_frame_packer

Framing stage between the host-side 32-bit command FIFO and the 128-bit AES core. It pops framed 32-bit words from the upstream FIFO and assembles them into 128-bit key and plaintext blocks for the core. It unpacks each 128-bit core result into four 32-bit words written to the return FIFO, which the host then drains over the register read path.

## Interface
Parameters:
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk_main_a0  in  1  sole clock.
- rst_main_n_sync  in  1  reset, asynchronous assert, active-low.
- data_empty  in  1  upstream FIFO empty.
- data_rd  out  1  upstream FIFO pop, combinational.
- data_din  in  32  upstream FIFO data, valid the cycle after data_rd.
- data_full  in  1  return FIFO full.
- data_wr  out  1  return FIFO push, combinational.
- data_dout  out  32  return FIFO data, valid with data_wr.
- key_out  out  128  key to core, held until next LOAD_KEY.
- key_valid  out  1  one-cycle pulse when key_out updates.
- blk_out  out  128  plaintext block to core.
- blk_valid  out  1  plaintext valid; held until blk_ready.
- blk_ready  in  1  core accepts blk_out.
- res_in  in  128  ciphertext from core.
- res_valid  in  1  ciphertext valid.
- res_ready  out  1  this block accepts res_in.
- err_cnt  out  ERR_W  saturating count of framing errors.
- key_loaded  out  1  set after the first LOAD_KEY completes.

## Operation
- Frame: header word, then 4 payload words, most significant first (word 0 goes to bits [127:96]). Header [31:28]: 4'h1 = LOAD_KEY, 4'h2 = ENCRYPT. Header [27:0] is ignored.
- Read rule: data_rd = fetch state && !data_empty && !rd_pending. rd_pending is set on the cycle after data_rd and cleared on capture. data_din is captured only while rd_pending is 1. This gives at most one pop per 2 cycles.
- Input FSM, IDLE -> HDR:
  - Pop a header.
  - Valid opcode -> PAYLOAD with word counter = 0.
  - Unknown opcode -> word dropped, err_cnt++, stay in HDR.
- PAYLOAD: pop and shift in 4 words; the counter wraps 3 -> done.
  - LOAD_KEY: key_out <= assembled value, key_valid pulses 1 cycle, key_loaded <= 1, -> HDR.
  - ENCRYPT with key_loaded = 1: blk_out <= assembled value -> ISSUE.
  - ENCRYPT with key_loaded = 0: payload discarded, err_cnt++, -> HDR.
- ISSUE: blk_valid = 1. When blk_valid && blk_ready -> HDR. No FIFO pops happen while in ISSUE.
- Output FSM, OUT_IDLE -> OUT_WORDS:
  - res_ready = 1 only in OUT_IDLE.
  - res_valid && res_ready latches res_in into a shift register and clears the word count.
  - In OUT_WORDS: data_wr = !data_full and data_dout = shreg[127:96]. On each push, shift left 32 and increment the count. After the 4th push -> OUT_IDLE.
- The input and output FSMs run independently, so a new block may be issued while a previous result is still unpacking.
- err_cnt saturates at all-ones and never wraps.

## Timing
- Reset values:
  - data_rd, data_wr, key_valid, blk_valid, key_loaded = 0.
  - err_cnt, key_out, blk_out, data_dout = 0.
  - res_ready = 1.
  - Both FSMs go to IDLE/OUT_IDLE and rd_pending = 0.
- Reset asserted mid-frame discards the partial frame and any unsent result words. key_loaded is cleared.
- Latency, in cycles from the header pop with the FIFO never empty:
  - Header captured at +1.
  - Last payload word captured at +9.
  - blk_valid or key_valid asserted at +10.
- Result latched at res_valid+0 edge. First data_wr in the next cycle if !data_full. 4 words in 4 cycles with no backpressure.
- data_full high: data_wr is held low and the word is held; no data is lost.
- data_empty high while awaiting a word: data_rd stays low and the state and counter are held.
- blk_ready low: blk_valid and blk_out are held stable.
- res_valid while in OUT_WORDS: it is not accepted because res_ready = 0, and the core must hold it.
- Simultaneous capture and err_cnt at saturation: err_cnt stays at max.

## Test plan
- Push 1000_0000, 00010203, 04050607, 08090A0B, 0C0D0E0F. Required: key_out = 000102030405060708090A0B0C0D0E0F, key_valid high exactly 1 cycle, key_loaded = 1.
- Push ENCRYPT header 2000_0000 with no key loaded, then 4 words. Required: blk_valid never asserts, err_cnt = 1, FIFO fully drained.
- Load a key, then send ENCRYPT 2000_0000 with payload 00112233, 44556677, 8899AABB, CCDDEEFF, and hold blk_ready = 0 for 5 cycles. Required: blk_out = 00112233445566778899AABBCCDDEEFF held stable, data_rd = 0 throughout, accept on blk_ready.
- Drive res_in = 69C4E0D86A7B0430D8CDB78070B4C55A with res_valid, and hold data_full = 1 for 3 cycles after the second push. Required: data_dout sequence 69C4E0D8, 6A7B0430, D8CDB780, 70B4C55A with no duplicates or losses, and res_ready low until the 4th push.
- Push 300 headers F000_0000. Required: err_cnt saturates at FF, and a following valid LOAD_KEY frame still works.
- Assert reset after the 2nd payload word of an ENCRYPT frame. Required: all outputs at reset values immediately, and a following fresh LOAD_KEY frame decodes correctly.

Source files
------------

// File: rtl/aes_frame_packer.sv
// Frames 32-bit host FIFO words into 128-bit key/plaintext blocks for the AES core,
// and unpacks 128-bit core results into four 32-bit return-FIFO words.
module aes_frame_packer #(
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk_main_a0,
    input  logic             rst_main_n_sync,
    input  logic             data_empty,
    output logic             data_rd,
    input  logic [31:0]      data_din,
    input  logic             data_full,
    output logic             data_wr,
    output logic [31:0]      data_dout,
    output logic [127:0]     key_out,
    output logic             key_valid,
    output logic [127:0]     blk_out,
    output logic             blk_valid,
    input  logic             blk_ready,
    input  logic [127:0]     res_in,
    input  logic             res_valid,
    output logic             res_ready,
    output logic [ERR_W-1:0] err_cnt,
    output logic             key_loaded
);

    typedef enum logic [1:0] {StIdle, StHdr, StPayload, StIssue} in_state_e;
    typedef enum logic {OutIdle, OutWords} out_state_e;

    localparam logic [3:0] OpLoadKey = 4'h1;
    localparam logic [3:0] OpEncrypt = 4'h2;

    in_state_e        in_state_q, in_state_d;
    logic             rd_pending_q, rd_pending_d;
    logic [1:0]       wcnt_q, wcnt_d;
    logic [95:0]      asm_q, asm_d;
    logic             is_key_q, is_key_d;
    logic [127:0]     key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic [127:0]     blk_q, blk_d;
    logic             key_loaded_q, key_loaded_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             err_inc;
    logic [127:0]     full_word;

    out_state_e       out_state_q, out_state_d;
    logic [1:0]       ocnt_q, ocnt_d;
    logic [127:0]     shreg_q, shreg_d;

    // Pending flag guarantees the popped word is captured before the next pop.
    assign data_rd   = (in_state_q == StHdr || in_state_q == StPayload) &&
                       !data_empty && !rd_pending_q;
    assign full_word = {asm_q, data_din};

    assign key_out    = key_q;
    assign key_valid  = key_valid_q;
    assign blk_out    = blk_q;
    assign blk_valid  = (in_state_q == StIssue);
    assign err_cnt    = err_q;
    assign key_loaded = key_loaded_q;

    assign data_wr   = (out_state_q == OutWords) && !data_full;
    assign data_dout = shreg_q[127:96];
    assign res_ready = (out_state_q == OutIdle);

    always_comb begin
        in_state_d   = in_state_q;
        rd_pending_d = data_rd;
        wcnt_d       = wcnt_q;
        asm_d        = asm_q;
        is_key_d     = is_key_q;
        key_d        = key_q;
        key_valid_d  = 1'b0;
        blk_d        = blk_q;
        key_loaded_d = key_loaded_q;
        err_inc      = 1'b0;
        err_d        = err_q;

        case (in_state_q)
            StIdle: in_state_d = StHdr;
            StHdr: begin
                if (rd_pending_q) begin
                    case (data_din[31:28])
                        OpLoadKey: begin
                            is_key_d   = 1'b1;
                            wcnt_d     = 2'd0;
                            in_state_d = StPayload;
                        end
                        OpEncrypt: begin
                            is_key_d   = 1'b0;
                            wcnt_d     = 2'd0;
                            in_state_d = StPayload;
                        end
                        default: err_inc = 1'b1;
                    endcase
                end
            end
            StPayload: begin
                if (rd_pending_q) begin
                    asm_d  = full_word[95:0];
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == 2'd3) begin
                        if (is_key_q) begin
                            key_d        = full_word;
                            key_valid_d  = 1'b1;
                            key_loaded_d = 1'b1;
                            in_state_d   = StHdr;
                        end else if (key_loaded_q) begin
                            blk_d      = full_word;
                            in_state_d = StIssue;
                        end else begin
                            err_inc    = 1'b1;
                            in_state_d = StHdr;
                        end
                    end
                end
            end
            StIssue: begin
                if (blk_ready) begin
                    in_state_d = StHdr;
                end
            end
            default: in_state_d = StIdle;
        endcase

        if (err_inc && err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + 1'b1;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        ocnt_d      = ocnt_q;
        shreg_d     = shreg_q;

        case (out_state_q)
            OutIdle: begin
                if (res_valid) begin
                    shreg_d     = res_in;
                    ocnt_d      = 2'd0;
                    out_state_d = OutWords;
                end
            end
            OutWords: begin
                if (data_wr) begin
                    shreg_d = {shreg_q[95:0], 32'h0};
                    ocnt_d  = ocnt_q + 2'd1;
                    if (ocnt_q == 2'd3) begin
                        out_state_d = OutIdle;
                    end
                end
            end
            default: out_state_d = OutIdle;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            in_state_q   <= StIdle;
            rd_pending_q <= 1'b0;
            wcnt_q       <= 2'd0;
            asm_q        <= '0;
            is_key_q     <= 1'b0;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            blk_q        <= '0;
            key_loaded_q <= 1'b0;
            err_q        <= '0;
            out_state_q  <= OutIdle;
            ocnt_q       <= 2'd0;
            shreg_q      <= '0;
        end else begin
            in_state_q   <= in_state_d;
            rd_pending_q <= rd_pending_d;
            wcnt_q       <= wcnt_d;
            asm_q        <= asm_d;
            is_key_q     <= is_key_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            blk_q        <= blk_d;
            key_loaded_q <= key_loaded_d;
            err_q        <= err_d;
            out_state_q  <= out_state_d;
            ocnt_q       <= ocnt_d;
            shreg_q      <= shreg_d;
        end
    end

endmodule

// File: tb/tb_aes_frame_packer.sv
// Self-checking bench for aes_frame_packer: FIFO/core models plus a frame-level
// reference model that predicts keys, blocks, error count and return words.
module tb_aes_frame_packer;

    localparam int unsigned ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             data_empty = 1'b1;
    logic             data_rd;
    logic [31:0]      data_din = '0;
    logic             data_full = 1'b0;
    logic             data_wr;
    logic [31:0]      data_dout;
    logic [127:0]     key_out;
    logic             key_valid;
    logic [127:0]     blk_out;
    logic             blk_valid;
    logic             blk_ready = 1'b1;
    logic [127:0]     res_in = '0;
    logic             res_valid = 1'b0;
    logic             res_ready;
    logic [ERR_W-1:0] err_cnt;
    logic             key_loaded;

    aes_frame_packer #(.ERR_W(ERR_W)) dut (
        .clk_main_a0     (clk),
        .rst_main_n_sync (rst_n),
        .data_empty      (data_empty),
        .data_rd         (data_rd),
        .data_din        (data_din),
        .data_full       (data_full),
        .data_wr         (data_wr),
        .data_dout       (data_dout),
        .key_out         (key_out),
        .key_valid       (key_valid),
        .blk_out         (blk_out),
        .blk_valid       (blk_valid),
        .blk_ready       (blk_ready),
        .res_in          (res_in),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .err_cnt         (err_cnt),
        .key_loaded      (key_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0]  in_q[$];
    logic [31:0]  out_q[$];
    logic [127:0] key_q[$];
    logic [127:0] blk_q[$];
    int           model_err;
    bit           model_loaded;

    int cyc, total_pops, key_pulses, blk_accepts, pushes, res_accepts, rd_in_issue;
    int first_rd_cyc, first_key_cyc, acc_cyc0, first_wr_cyc;
    bit rand_mode;
    bit res_next_pending;
    logic [127:0] res_next;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic bump_err();
        if (model_err < 255) model_err++;
    endtask

    // Frame-level model: predicts what each frame must produce.
    task automatic send_frame(input logic [3:0] op, input logic [127:0] payload);
        logic [27:0] junk;
        junk = 28'($urandom);
        in_q.push_back({op, junk});
        if (op == 4'h1 || op == 4'h2) begin
            for (int k = 0; k < 4; k++) in_q.push_back(payload[127-32*k -: 32]);
        end
        if (op == 4'h1) begin
            key_q.push_back(payload);
            model_loaded = 1'b1;
        end else if (op == 4'h2 && model_loaded) begin
            blk_q.push_back(payload);
        end else begin
            bump_err();
        end
    endtask

    task automatic tick();
        bit pop, acc;
        @(negedge clk);
        cyc++;
        if (data_wr) begin
            pushes++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (out_q.size() == 0) check("dout_unexpected", 1, 0);
            else check("dout", data_dout, out_q.pop_front());
        end
        if (key_valid) begin
            key_pulses++;
            if (first_key_cyc < 0) first_key_cyc = cyc;
            if (key_q.size() == 0) check("key_unexpected", 1, 0);
            else check("key_out", key_out, key_q.pop_front());
        end
        if (blk_valid && data_rd) rd_in_issue++;
        if (blk_valid && blk_ready) begin
            blk_accepts++;
            if (blk_q.size() == 0) check("blk_unexpected", 1, 0);
            else check("blk_out", blk_out, blk_q.pop_front());
        end
        if (data_rd && first_rd_cyc < 0) first_rd_cyc = cyc;
        acc = res_valid && res_ready;
        if (acc) begin
            res_accepts++;
            if (acc_cyc0 < 0) acc_cyc0 = cyc;
            for (int k = 0; k < 4; k++) out_q.push_back(res_in[127-32*k -: 32]);
        end
        pop = data_rd;
        @(posedge clk);
        #1;
        if (pop) begin
            total_pops++;
            if (in_q.size() == 0) check("pop_from_empty", 1, 0);
            else data_din = in_q.pop_front();
        end
        if (acc) begin
            if (res_next_pending) begin
                res_in = res_next;
                res_next_pending = 1'b0;
            end else begin
                res_valid = 1'b0;
            end
        end
        if (rand_mode) begin
            data_full = ($urandom_range(0, 3) == 0);
            blk_ready = 1'($urandom_range(0, 1));
            if (!res_valid && $urandom_range(0, 9) == 0) begin
                res_valid = 1'b1;
                res_in = rand128();
            end
        end
        data_empty = (in_q.size() == 0) || (rand_mode && $urandom_range(0, 3) == 0);
    endtask

    task automatic run_idle(input int max);
        int quiet = 0;
        int n = 0;
        while (quiet < 12 && n < max) begin
            tick();
            n++;
            if (in_q.size() == 0 && out_q.size() == 0 && !blk_valid && !res_valid) quiet++;
            else quiet = 0;
        end
        check("idle_reached", quiet >= 12, 1);
    endtask

    task automatic check_reset_vals();
        check("rst_data_rd", data_rd, 0);
        check("rst_data_wr", data_wr, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_blk_valid", blk_valid, 0);
        check("rst_key_loaded", key_loaded, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_key_out", key_out, 0);
        check("rst_blk_out", blk_out, 0);
        check("rst_data_dout", data_dout, 0);
        check("rst_res_ready", res_ready, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        in_q.delete();
        out_q.delete();
        key_q.delete();
        blk_q.delete();
        model_err = 0;
        model_loaded = 1'b0;
        res_valid = 1'b0;
        res_next_pending = 1'b0;
        data_empty = 1'b1;
        data_full = 1'b0;
        blk_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] k5, k6;
        int base, n;
        bit stalled;
        first_rd_cyc = -1;
        first_key_cyc = -1;
        acc_cyc0 = -1;
        first_wr_cyc = -1;
        #3;
        do_reset();

        // Encrypt with no key loaded: error, no block, FIFO drained.
        blk_accepts = 0;
        send_frame(4'h2, rand128());
        run_idle(100);
        check("nokey_blk_accepts", blk_accepts, 0);
        check("nokey_err_cnt", err_cnt, 1);
        check("nokey_drained", in_q.size(), 0);

        // Key load with latency measurement.
        key_pulses = 0;
        first_rd_cyc = -1;
        first_key_cyc = -1;
        send_frame(4'h1, 128'h000102030405060708090A0B0C0D0E0F);
        run_idle(100);
        check("key_pulse_count", key_pulses, 1);
        check("key_loaded", key_loaded, 1);
        check("key_value", key_out, 128'h000102030405060708090A0B0C0D0E0F);
        check("key_latency", first_key_cyc - first_rd_cyc, 10);

        // Encrypt with blk_ready held low; a queued frame must not be popped.
        blk_accepts = 0;
        rd_in_issue = 0;
        blk_ready = 1'b0;
        send_frame(4'h2, 128'h00112233445566778899AABBCCDDEEFF);
        send_frame(4'h1, rand128());
        for (n = 0; n < 40 && !blk_valid; n++) tick();
        check("blk_valid_seen", blk_valid, 1);
        repeat (5) begin
            tick();
            check("blk_hold", blk_out, 128'h00112233445566778899AABBCCDDEEFF);
            check("blk_valid_hold", blk_valid, 1);
            check("no_rd_in_issue", data_rd, 0);
        end
        blk_ready = 1'b1;
        run_idle(100);
        check("blk_accepts", blk_accepts, 1);
        check("rd_in_issue", rd_in_issue, 0);

        // Result unpacking with backpressure and a second result waiting.
        pushes = 0;
        res_accepts = 0;
        acc_cyc0 = -1;
        first_wr_cyc = -1;
        stalled = 1'b0;
        res_in = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
        res_valid = 1'b1;
        res_next = rand128();
        res_next_pending = 1'b1;
        for (int i = 0; i < 40 && pushes < 8; i++) begin
            tick();
            if (pushes == 2 && !stalled) begin
                stalled = 1'b1;
                data_full = 1'b1;
                repeat (3) begin
                    tick();
                    check("no_wr_while_full", pushes, 2);
                end
                data_full = 1'b0;
            end
            if (pushes > 0 && pushes < 4) check("res_ready_busy", res_ready, 0);
        end
        check("res_pushes", pushes, 8);
        check("res_accepts", res_accepts, 2);
        check("first_wr_latency", first_wr_cyc - acc_cyc0, 1);
        run_idle(100);

        // Error counter saturation, then a valid key load.
        k5 = rand128();
        for (int i = 0; i < 300; i++) send_frame(4'hF, '0);
        send_frame(4'h1, k5);
        run_idle(2000);
        check("err_saturated", err_cnt, 8'hFF);
        check("err_model", err_cnt, model_err);
        check("sat_key_out", key_out, k5);
        check("sat_key_loaded", key_loaded, 1);

        // Reset mid-frame with result words still pending behind data_full.
        send_frame(4'h2, rand128());
        data_full = 1'b1;
        res_in = rand128();
        res_valid = 1'b1;
        base = total_pops;
        for (n = 0; n < 40 && total_pops < base + 3; n++) tick();
        check("midframe_pops", total_pops, base + 3);
        tick();
        do_reset();
        k6 = rand128();
        key_pulses = 0;
        send_frame(4'h1, k6);
        run_idle(100);
        check("post_rst_key", key_out, k6);
        check("post_rst_pulses", key_pulses, 1);
        check("post_rst_err", err_cnt, 0);

        // Randomized frames with random stalls on every handshake.
        do_reset();
        rand_mode = 1'b1;
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 4))
                0:       send_frame(4'h1, rand128());
                4:       send_frame(4'($urandom_range(3, 15)), '0);
                default: send_frame(4'h2, rand128());
            endcase
        end
        for (n = 0; n < 3000 && in_q.size() != 0; n++) tick();
        rand_mode = 1'b0;
        data_full = 1'b0;
        blk_ready = 1'b1;
        run_idle(200);
        check("rand_err_cnt", err_cnt, model_err);
        check("rand_key_left", key_q.size(), 0);
        check("rand_blk_left", blk_q.size(), 0);
        check("rand_out_left", out_q.size(), 0);
        check("rand_key_loaded", key_loaded, model_loaded);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
